// File: rtl/decoder_pkg.sv
// Shared widths and the one-hot word type for the 3-to-8 decoder slice.
package decoder_pkg;
    localparam int CODE_W = 3;
    localparam int OUT_W  = 8;

    typedef logic [OUT_W-1:0] onehot_t;
endpackage

// File: rtl/skid_fifo2.sv
// Generic 2-entry valid/ready FIFO; ready and valid derive only from registered occupancy.
module skid_fifo2 #(
    parameter int OUT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push_valid,
    output logic             o_push_ready,
    input  logic [OUT_W-1:0] i_push_data,
    output logic             o_pop_valid,
    input  logic             i_pop_ready,
    output logic [OUT_W-1:0] o_pop_data
);
    logic [OUT_W-1:0] r_mem [2];
    logic             r_rd_ptr;
    logic             r_wr_ptr;
    logic [1:0]       r_count;
    logic             w_push;
    logic             w_pop;

    assign o_push_ready = (r_count != 2'd2);
    assign o_pop_valid  = (r_count != 2'd0);
    // Empty FIFO presents zero so stale entries never leak downstream.
    assign o_pop_data   = o_pop_valid ? r_mem[r_rd_ptr] : '0;
    assign w_push       = i_push_valid & o_push_ready;
    assign w_pop        = o_pop_valid & i_pop_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/decoder3x8_hs.sv
// Registered 3-to-8 one-hot decoder with valid/ready on both sides and a
// saturating count of delivered words. Code and output widths come from decoder_pkg.
module decoder3x8_hs
    import decoder_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic [CODE_W-1:0] code_in,
    input  logic              en_in,
    input  logic              in_valid_in,
    output logic              in_ready_out,
    output logic [OUT_W-1:0]  onehot_out,
    output logic              out_valid_out,
    input  logic              out_ready_in,
    output logic [CNT_W-1:0]  count_out
);
    function automatic onehot_t f_decode(input logic [CODE_W-1:0] code, input logic en);
        f_decode = en ? (onehot_t'(1) << code) : '0;
    endfunction

    onehot_t          w_word;
    logic             w_pop;
    logic [CNT_W-1:0] r_count;

    // Decode before the FIFO so the output path is purely registered.
    assign w_word = f_decode(code_in, en_in);

    skid_fifo2 #(
        .OUT_W(OUT_W)
    ) u_fifo (
        .i_clk       (clk_in),
        .i_rst_n     (rst_n_in),
        .i_push_valid(in_valid_in),
        .o_push_ready(in_ready_out),
        .i_push_data (w_word),
        .o_pop_valid (out_valid_out),
        .i_pop_ready (out_ready_in),
        .o_pop_data  (onehot_out)
    );

    assign w_pop = out_valid_out & out_ready_in;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_count <= '0;
        end else if (w_pop && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign count_out = r_count;
endmodule

// File: tb/tb_decoder3x8_hs.sv
// Randomized and directed bench for decoder3x8_hs against a queue-based model.
module tb_decoder3x8_hs;
    logic       clk_in = 1'b0;
    logic       rst_n_in;
    logic [2:0] code_in;
    logic       en_in;
    logic       in_valid_in;
    logic       in_ready_out;
    logic [7:0] onehot_out;
    logic       out_valid_out;
    logic       out_ready_in;
    logic [7:0] count_out;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] q[$];
    int         m_count = 0;
    bit         acc;

    decoder3x8_hs dut (
        .clk_in       (clk_in),
        .rst_n_in     (rst_n_in),
        .code_in      (code_in),
        .en_in        (en_in),
        .in_valid_in  (in_valid_in),
        .in_ready_out (in_ready_out),
        .onehot_out   (onehot_out),
        .out_valid_out(out_valid_out),
        .out_ready_in (out_ready_in),
        .count_out    (count_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: compare outputs mid-cycle, then advance the model at the edge.
    task automatic cycle(output bit accepted);
        logic [7:0] exp_head;
        bit do_push, do_pop;
        @(negedge clk_in);
        exp_head = (q.size() > 0) ? q[0] : 8'h00;
        chk("in_ready", in_ready_out, q.size() < 2);
        chk("out_valid", out_valid_out, q.size() > 0);
        chk("onehot", onehot_out, exp_head);
        chk("count", count_out, m_count);
        if (out_valid_out) chk("popcount_le1", $countones(onehot_out) <= 1, 1);
        do_push = in_valid_in && (q.size() < 2);
        do_pop  = (q.size() > 0) && out_ready_in;
        @(posedge clk_in);
        if (do_pop) begin
            void'(q.pop_front());
            if (m_count < 255) m_count++;
        end
        if (do_push) q.push_back(en_in ? (8'd1 << code_in) : 8'h00);
        accepted = do_push;
        #1;
    endtask

    initial begin
        rst_n_in = 1'b0;
        code_in = 3'd0;
        en_in = 1'b0;
        in_valid_in = 1'b0;
        out_ready_in = 1'b0;
        #2;
        chk("rst_valid", out_valid_out, 0);
        chk("rst_onehot", onehot_out, 0);
        chk("rst_count", count_out, 0);
        chk("rst_ready", in_ready_out, 1);
        @(posedge clk_in);
        #1 rst_n_in = 1'b1;

        // Sweep all codes at full throughput
        out_ready_in = 1'b1;
        for (int c = 0; c < 8; c++) begin
            in_valid_in = 1'b1;
            code_in = 3'(c);
            en_in = 1'b1;
            cycle(acc);
            chk("sweep_acc", acc, 1);
        end
        in_valid_in = 1'b0;
        cycle(acc);
        cycle(acc);
        chk("sweep_count", count_out, 8);

        // Enable off stores a zero word that still counts
        in_valid_in = 1'b1;
        code_in = 3'd5;
        en_in = 1'b0;
        cycle(acc);
        in_valid_in = 1'b0;
        cycle(acc);
        cycle(acc);
        chk("en_off_count", count_out, 9);

        // Back-pressure: 3, 6 fill the FIFO, 1 is held
        out_ready_in = 1'b0;
        en_in = 1'b1;
        in_valid_in = 1'b1;
        code_in = 3'd3;
        cycle(acc);
        code_in = 3'd6;
        cycle(acc);
        code_in = 3'd1;
        cycle(acc);
        chk("bp_held", acc, 0);
        chk("bp_ready", in_ready_out, 0);
        chk("bp_head", onehot_out, 8'h08);
        cycle(acc);
        out_ready_in = 1'b1;
        acc = 1'b0;
        for (int k = 0; k < 10 && !acc; k++) cycle(acc);
        chk("bp_release_acc", acc, 1);
        in_valid_in = 1'b0;
        repeat (4) cycle(acc);
        chk("bp_count", count_out, 12);

        // Random traffic honouring the hold-while-stalled rule
        acc = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (!(in_valid_in && !acc)) begin
                in_valid_in = 1'($urandom_range(0, 1));
                code_in = 3'($urandom_range(0, 7));
                en_in = ($urandom_range(0, 3) != 0);
            end
            out_ready_in = 1'($urandom_range(0, 1));
            cycle(acc);
        end

        // Saturation: well over 255 pops in total
        out_ready_in = 1'b1;
        in_valid_in = 1'b1;
        for (int i = 0; i < 300; i++) begin
            code_in = 3'($urandom_range(0, 7));
            en_in = 1'($urandom_range(0, 1));
            cycle(acc);
        end
        in_valid_in = 1'b0;
        repeat (3) cycle(acc);
        chk("sat_count", count_out, 255);

        // Async reset between edges with two words buffered
        out_ready_in = 1'b0;
        in_valid_in = 1'b1;
        en_in = 1'b1;
        code_in = 3'd2;
        cycle(acc);
        code_in = 3'd7;
        cycle(acc);
        in_valid_in = 1'b0;
        chk("pre_rst_full", in_ready_out, 0);
        @(negedge clk_in);
        #2 rst_n_in = 1'b0;
        #1;
        chk("arst_valid", out_valid_out, 0);
        chk("arst_onehot", onehot_out, 0);
        chk("arst_count", count_out, 0);
        chk("arst_ready", in_ready_out, 1);
        q.delete();
        m_count = 0;
        @(posedge clk_in);
        #2 rst_n_in = 1'b1;
        out_ready_in = 1'b1;
        cycle(acc);
        in_valid_in = 1'b1;
        code_in = 3'd4;
        cycle(acc);
        in_valid_in = 1'b0;
        repeat (2) cycle(acc);
        chk("post_rst_count", count_out, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
